// File: rtl/pool_row_arbiter.sv
`timescale 1ns / 1ps
// ============================================================================
// pool_row_arbiter
//
// Purpose:
//   Shares one 2x2 max-pool/ReLU datapath between NUM_CH channels. Each
//   channel's line-buffer controller raises i_req when a full row-pair of
//   windows is ready. The arbiter grants one channel at a time, round-robin,
//   for exactly BURST_LEN accepted windows. While a burst runs, the granted
//   channel's window stream is muxed straight through to the pool stage,
//   and a read strobe is returned to that channel.
//
//   FSM: IDLE (arbitrate) -> BURST (stream) -> RELEASE (one dead cycle so
//   the finished requester can drop i_req) -> IDLE.
//
// Optional feature (macro POOL_ARB_WATCHDOG_EN):
//   A stall watchdog aborts a burst after WDOG_CYCLES consecutive cycles
//   without a valid window from the granted channel. It also sets the
//   sticky o_err flag. When the macro is undefined, o_err is tied low and a
//   burst waits forever.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_req         per-channel row-pair ready (level)
//   i_data        per-channel 2x2 window, channel k at [k*4*DATA_W +: 4*DATA_W]
//   i_data_valid  per-channel window valid
//   i_pool_ready  shared pool stage can accept a window
//   o_gnt         one-hot grant (registered)
//   o_rd          per-channel window-consumed strobe (combinational)
//   o_data        window from the granted channel (combinational)
//   o_data_valid  window valid toward the pool stage (combinational)
//   o_ch_id       index of the granted channel (registered)
//   o_last        accepted beat is the final window of the burst
//   o_busy        burst in progress (registered)
//   o_err         sticky watchdog abort flag
// ============================================================================
module pool_row_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 13,
    parameter int BURST_LEN   = 256,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_CH-1:0]          i_req,
    input  logic [NUM_CH*4*DATA_W-1:0] i_data,
    input  logic [NUM_CH-1:0]          i_data_valid,
    input  logic                       i_pool_ready,
    output logic [NUM_CH-1:0]          o_gnt,
    output logic [NUM_CH-1:0]          o_rd,
    output logic [4*DATA_W-1:0]        o_data,
    output logic                       o_data_valid,
    output logic [2:0]                 o_ch_id,
    output logic                       o_last,
    output logic                       o_busy,
    output logic                       o_err
);

    localparam int WIN_W = 4 * DATA_W;
    localparam int PTR_W = $clog2(NUM_CH);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    // Reject parameter sets the datapath cannot represent (o_ch_id is 3 bits).
    if (NUM_CH < 2 || NUM_CH > 8 || BURST_LEN < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("pool_row_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_CH-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]   ch_q, ch_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic               cur_valid;
    logic               accept;
    logic               end_burst;

`ifdef POOL_ARB_WATCHDOG_EN
    localparam int STALL_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(WDOG_CYCLES - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;
`endif

    // (base + off) mod NUM_CH for off in 1..NUM_CH; one subtract is enough.
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        return PTR_W'(sum);
    endfunction

    // Round-robin pick: first requester after the last served channel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            if (!pick_found && i_req[rr_index(rr_ptr_q, off)]) begin
                pick_found = 1'b1;
                pick_idx   = rr_index(rr_ptr_q, off);
            end
        end
    end

    // Next-state and datapath outputs.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ch_d         = ch_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
`ifdef POOL_ARB_WATCHDOG_EN
        stall_d      = stall_q;
        err_d        = err_q;
`endif
        o_data       = '0;
        o_data_valid = 1'b0;
        o_rd         = '0;
        o_last       = 1'b0;
        cur_valid    = i_data_valid[ch_q];
        accept       = 1'b0;
        end_burst    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_BURST;
                    gnt_d   = NUM_CH'(1) << pick_idx;
                    ch_d    = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
`ifdef POOL_ARB_WATCHDOG_EN
                    stall_d = '0;
`endif
                end
            end

            ST_BURST: begin
                o_data       = i_data[int'(ch_q)*WIN_W +: WIN_W];
                o_data_valid = cur_valid;
                accept       = cur_valid & i_pool_ready;
                if (accept) begin
                    o_rd = NUM_CH'(1) << ch_q;
                    if (cnt_q == CNT_MAX) begin
                        o_last    = 1'b1;
                        end_burst = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef POOL_ARB_WATCHDOG_EN
                // Only a missing valid counts as a stall; back-pressure
                // from the pool stage does not.
                if (cur_valid) begin
                    stall_d = '0;
                end else if (stall_q == STALL_MAX) begin
                    end_burst = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
                if (end_burst) begin
                    state_d  = ST_RELEASE;
                    gnt_d    = '0;
                    ch_d     = '0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    rr_ptr_d = ch_q;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: all state is a handful of flops, so every register is
        // reset; a synchronous reset abandons any burst on the next edge.
        if (i_rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            ch_q     <= '0;
            rr_ptr_q <= PTR_W'(NUM_CH - 1);
            cnt_q    <= '0;
            busy_q   <= 1'b0;
`ifdef POOL_ARB_WATCHDOG_EN
            stall_q  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ch_q     <= ch_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
`ifdef POOL_ARB_WATCHDOG_EN
            stall_q  <= stall_d;
            err_q    <= err_d;
`endif
        end
    end

    assign o_gnt   = gnt_q;
    assign o_busy  = busy_q;
    assign o_ch_id = 3'(ch_q);
`ifdef POOL_ARB_WATCHDOG_EN
    assign o_err   = err_q;
`else
    assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pool_row_arbiter.sv
`timescale 1ns / 1ps
// ============================================================================
// tb_pool_row_arbiter
//
// Directed bench for pool_row_arbiter with default parameters
// (4 channels, 13-bit pixels, 256-window bursts, 64-cycle watchdog).
// Builds with or without POOL_ARB_WATCHDOG_EN; the stall sequence checks
// the behaviour that matches the build.
// ============================================================================
module tb_pool_row_arbiter;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 13;
    localparam int BURST_LEN = 256;
    localparam int WDOG      = 64;
    localparam int WIN_W     = 4 * DATA_W;

    logic                       clk;
    logic                       rst;
    logic [NUM_CH-1:0]          req;
    logic [NUM_CH*WIN_W-1:0]    data;
    logic [NUM_CH-1:0]          data_valid;
    logic                       pool_ready;
    logic [NUM_CH-1:0]          gnt;
    logic [NUM_CH-1:0]          rd;
    logic [WIN_W-1:0]           out_data;
    logic                       out_valid;
    logic [2:0]                 ch_id;
    logic                       last;
    logic                       busy;
    logic                       err;

    int tests_run;
    int tests_failed;

    pool_row_arbiter #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .BURST_LEN   (BURST_LEN),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_data       (data),
        .i_data_valid (data_valid),
        .i_pool_ready (pool_ready),
        .o_gnt        (gnt),
        .o_rd         (rd),
        .o_data       (out_data),
        .o_data_valid (out_valid),
        .o_ch_id      (ch_id),
        .o_last       (last),
        .o_busy       (busy),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, easily recognisable window per channel.
    function automatic logic [WIN_W-1:0] win(input int k);
        return {13'(16'h1000 + k * 4 + 1), 13'(16'h0800 + k * 4 + 2),
                13'(16'h0400 + k * 4 + 3), 13'(16'h0200 + k * 4 + 4)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the bench 1 ns after a rising edge: registered outputs settled,
    // safe to drive new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Counts grant-free cycles until a grant appears (bounded).
    task automatic wait_grant(output int gap, output logic [NUM_CH-1:0] g);
        gap = 0;
        while (gnt == '0 && gap < 20) begin
            gap++;
            tick();
        end
        g = gnt;
    endtask

    // Streams one burst from exp_ch with all valids high.
    // toggle_ready=1 drives ready high on even cycles and low on odd cycles.
    task automatic run_burst(input int exp_ch, input bit toggle_ready,
                             output int beats, output int cycles,
                             output int last_beat, output int bad);
        bit last_seen;
        logic [NUM_CH-1:0] own;
        beats     = 0;
        cycles    = 0;
        last_beat = -1;
        bad       = 0;
        last_seen = 1'b0;
        own       = NUM_CH'(1) << exp_ch;
        while (!last_seen && cycles < 3000) begin
            pool_ready = toggle_ready ? (cycles % 2 == 0) : 1'b1;
            #1;
            if ((rd & ~own) != '0)           bad++;
            if (rd[exp_ch] != pool_ready)    bad++;
            if (out_data != win(exp_ch))     bad++;
            if (!out_valid)                  bad++;
            if (rd[exp_ch]) beats++;
            if (last) begin
                last_seen = 1'b1;
                last_beat = beats;
                if (!rd[exp_ch]) bad++;
            end
            cycles++;
            tick();
        end
        pool_ready = 1'b1;
    endtask

    typedef struct {
        logic [NUM_CH-1:0] valid;
        logic              ready;
        logic              exp_dv;
        logic [NUM_CH-1:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int gap, beats, cycles, last_beat, bad, acc;
        logic [NUM_CH-1:0] g;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        req          = '0;
        data_valid   = '0;
        pool_ready   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) data[k*WIN_W +: WIN_W] = win(k);

        // Mux/strobe table, applied while channel 1 holds the grant.
        vecs[0] = '{4'b1111, 1'b1, 1'b1, 4'b0010};
        vecs[1] = '{4'b1111, 1'b0, 1'b1, 4'b0000};
        vecs[2] = '{4'b1101, 1'b1, 1'b0, 4'b0000};
        vecs[3] = '{4'b0010, 1'b1, 1'b1, 4'b0010};
        vecs[4] = '{4'b0010, 1'b0, 1'b1, 4'b0000};
        vecs[5] = '{4'b0000, 1'b0, 1'b0, 4'b0000};
        vecs[6] = '{4'b1101, 1'b0, 1'b0, 4'b0000};
        vecs[7] = '{4'b0010, 1'b1, 1'b1, 4'b0010};

        // ---------------- reset state ----------------
        do_reset();
        data_valid = 4'b1111;
        pool_ready = 1'b1;
        #1;
        check("rst_gnt",   64'(gnt),       64'h0);
        check("rst_busy",  64'(busy),      64'h0);
        check("rst_dv",    64'(out_valid), 64'h0);
        check("rst_rd",    64'(rd),        64'h0);
        check("rst_last",  64'(last),      64'h0);
        check("rst_chid",  64'(ch_id),     64'h0);
        check("rst_err",   64'(err),       64'h0);
        check("rst_data",  64'(out_data),  64'h0);

        // ---------------- single request, full-rate burst ----------------
        req = 4'b0001;
        tick();
        check("t1_gnt_latency", 64'(gnt),  64'h1);
        check("t1_busy",        64'(busy), 64'h1);
        run_burst(0, 1'b0, beats, cycles, last_beat, bad);
        check("t1_last_beat", 64'(last_beat), 64'd256);
        check("t1_cycles",    64'(cycles),    64'd256);
        check("t1_stream",    64'(bad),       64'h0);
        check("t1_gnt_clear", 64'(gnt),       64'h0);
        check("t1_busy_clear",64'(busy),      64'h0);
        check("t1_release_dv",64'(out_valid), 64'h0);

        // ---------------- all channels requesting ----------------
        do_reset();
        req = 4'b1111;
        for (int b = 0; b < NUM_CH; b++) begin
            wait_grant(gap, g);
            check($sformatf("t2_gnt%0d", b),  64'(g),     64'(NUM_CH'(1) << b));
            check($sformatf("t2_chid%0d", b), 64'(ch_id), 64'(b));
            if (b > 0) check($sformatf("t2_gap%0d", b), 64'(gap), 64'd2);
            if (b == NUM_CH - 1) req = 4'b0100;
            run_burst(b, 1'b0, beats, cycles, last_beat, bad);
            check($sformatf("t2_beats%0d", b),  64'(last_beat), 64'd256);
            check($sformatf("t2_stream%0d", b), 64'(bad),       64'h0);
        end

        // ---------------- ch2, ready toggling, req dropped mid-burst --------
        wait_grant(gap, g);
        check("t3_gnt", 64'(g),   64'h4);
        check("t3_gap", 64'(gap), 64'd2);
        req = '0;
        run_burst(2, 1'b1, beats, cycles, last_beat, bad);
        check("t3_last_beat", 64'(last_beat), 64'd256);
        check("t3_cycles",    64'(cycles),    64'd511);
        check("t3_rd_ready",  64'(bad),       64'h0);
        check("t3_gnt_clear", 64'(gnt),       64'h0);

        // ---------------- table vectors, then reset at beat 100 -------------
        do_reset();
        data_valid = 4'b1111;
        pool_ready = 1'b1;
        req = 4'b0010;
        wait_grant(gap, g);
        check("t4_gnt", 64'(g), 64'h2);
        req = '0;
        acc = 0;
        foreach (vecs[i]) begin
            data_valid = vecs[i].valid;
            pool_ready = vecs[i].ready;
            #1;
            check($sformatf("t4_vec%0d_dv", i),   64'(out_valid), 64'(vecs[i].exp_dv));
            check($sformatf("t4_vec%0d_rd", i),   64'(rd),        64'(vecs[i].exp_rd));
            check($sformatf("t4_vec%0d_last", i), 64'(last),      64'h0);
            check($sformatf("t4_vec%0d_data", i), 64'(out_data),  64'(win(1)));
            if (vecs[i].exp_rd[1]) acc++;
            tick();
        end
        data_valid = 4'b1111;
        pool_ready = 1'b1;
        while (acc < 99) begin
            acc++;
            tick();
        end
        // Beat 100 is on the wires now; reset lands on this edge.
        rst = 1'b1;
        tick();
        #1;
        check("t4_rst_gnt",  64'(gnt),       64'h0);
        check("t4_rst_busy", 64'(busy),      64'h0);
        check("t4_rst_dv",   64'(out_valid), 64'h0);
        check("t4_rst_rd",   64'(rd),        64'h0);
        check("t4_rst_last", 64'(last),      64'h0);
        rst = 1'b0;
        req = 4'b1111;
        wait_grant(gap, g);
        check("t4_next_gnt", 64'(g), 64'h1);

        // ---------------- valid stall on ch1 after 10 beats -----------------
        do_reset();
        data_valid = 4'b1111;
        pool_ready = 1'b1;
        req = 4'b0010;
        wait_grant(gap, g);
        check("t5_gnt", 64'(g), 64'h2);
        req = '0;
        for (int i = 0; i < 10; i++) tick();
        data_valid = 4'b1101;
        #1;
        check("t5_stall_dv", 64'(out_valid), 64'h0);
        for (int i = 0; i < WDOG - 1; i++) tick();
        check("t5_pre_gnt", 64'(gnt), 64'h2);
        check("t5_pre_err", 64'(err), 64'h0);
        tick();
`ifdef POOL_ARB_WATCHDOG_EN
        check("t5_wd_gnt",  64'(gnt),  64'h0);
        check("t5_wd_busy", 64'(busy), 64'h0);
        check("t5_wd_err",  64'(err),  64'h1);
        req = 4'b1111;
        wait_grant(gap, g);
        check("t5_wd_next", 64'(g),   64'h4);
        check("t5_wd_sticky", 64'(err), 64'h1);
`else
        for (int i = 0; i < 16; i++) tick();
        check("t5_hold_gnt",  64'(gnt),  64'h2);
        check("t5_hold_busy", 64'(busy), 64'h1);
        check("t5_hold_err",  64'(err),  64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pool_row_arbiter.md
# pool_row_arbiter

Shares one 2x2 pooling datapath between NUM_CH convolution channels, each owning its own pool line-buffer controller. Each channel raises a request when a complete row-pair of 2x2 windows is ready. The arbiter grants one channel at a time, round-robin, for exactly one burst of BURST_LEN windows. It muxes that channel's window stream to the shared pool unit and returns per-channel read strobes. It sits between the per-channel pool line-buffer controllers and the single max-pool/ReLU stage.

## Interface
- NUM_CH, 4, number of requesting channels (2..8)
- DATA_W, 13, pixel width (INTEGER_BITS+FIXED_POINT_BITS = 9+4)
- BURST_LEN, 256, windows per grant (one row-pair of a 512-wide map)
- WDOG_CYCLES, 64, watchdog limit (only with POOL_ARB_WATCHDOG_EN)

- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req  in  NUM_CH  per-channel row-pair ready; level, held until granted
- i_data  in  NUM_CH*4*DATA_W  per-channel 2x2 window; channel k at bits [k*4*DATA_W +: 4*DATA_W]
- i_data_valid  in  NUM_CH  per-channel window valid
- i_pool_ready  in  1  shared pool stage can accept a window
- o_gnt  out  NUM_CH  one-hot grant, registered
- o_rd  out  NUM_CH  per-channel window-consumed strobe
- o_data  out  4*DATA_W  window from granted channel
- o_data_valid  out  1  window valid toward pool stage
- o_ch_id  out  3  index of granted channel, registered
- o_last  out  1  accepted beat is the final window of the burst
- o_busy  out  1  burst in progress
- o_err  out  1  sticky watchdog abort flag

## Operation
- FSM states: IDLE, BURST, RELEASE.
- IDLE: if any i_req, pick the first requesting channel starting at rr_ptr+1 (mod NUM_CH). Register o_gnt, o_ch_id and o_busy=1. Clear beat counter. Go to BURST. If no request, stay in IDLE.
- BURST:
  - o_data = i_data[ch].
  - o_data_valid = i_data_valid[ch].
  - o_rd[ch] = i_data_valid[ch] & i_pool_ready. All other o_rd bits are 0.
  - A beat is accepted when o_data_valid & i_pool_ready. The beat counter (width clog2(BURST_LEN)) increments per accepted beat.
  - o_last = accepted beat & counter == BURST_LEN-1.
  - On that beat: clear o_gnt, set rr_ptr = ch, go to RELEASE.
- RELEASE: one idle cycle with o_busy=0 and all outputs inactive. Then go to IDLE. This gives the requester a cycle to drop i_req.
- Outside BURST: o_data=0, o_data_valid=0, o_rd=0, o_last=0.
- i_req is ignored while BURST or RELEASE. Requests are never lost; they are sampled again in IDLE.
- A channel dropping i_req mid-burst does not end the burst. Only BURST_LEN accepted beats end it (or the watchdog, when compiled in).
- Simultaneous requests from all channels: service order is rr_ptr+1, rr_ptr+2, ... with no starvation.
- rr_ptr wraps from NUM_CH-1 to 0.
- Reset values: rr_ptr=NUM_CH-1 (so the first grant goes to channel 0). State IDLE, counter 0, and every output 0.
- i_rst mid-burst: the burst is abandoned at the next edge, with no o_last and no o_rd afterwards.

## Timing
- i_req rising in IDLE -> o_gnt/o_busy asserted on the next edge (1-cycle grant latency).
- o_data, o_data_valid, o_rd and o_last are combinational from i_data_valid, i_pool_ready and registered state. Zero added data latency.
- Minimum burst duration is BURST_LEN cycles (no stalls).
- Back-to-back bursts are separated by exactly 2 cycles with no grant: RELEASE, then IDLE arbitration.
- i_pool_ready low: no beat is accepted, the counter holds and o_rd stays 0. o_data_valid may still be high.

## Configuration
- Macro: POOL_ARB_WATCHDOG_EN.
- Defined:
  - A stall counter counts consecutive BURST cycles where i_data_valid[ch]=0. It resets on any valid.
  - Reaching WDOG_CYCLES forces BURST->RELEASE, clears o_gnt, advances rr_ptr to ch and sets o_err=1.
  - o_err stays set until i_rst.
  - Stalls caused only by i_pool_ready=0 while valid is high do not count.
- Undefined: no stall counter; o_err is tied to 0; a burst waits indefinitely.

## Test plan
- Reset, i_req=4'b0001, valid and ready held high → o_gnt=0001 one cycle later. 256 accepted beats, o_last on beat 256, o_gnt=0 on the next edge.
- i_req=4'b1111 held for 4 bursts → grant order ch0, ch1, ch2, ch3, each exactly 256 beats, 2 grant-free cycles between bursts.
- Granted ch2 with i_pool_ready toggling 1/0 → o_rd[2] pulses only on ready-high cycles. The burst still ends after exactly 256 o_rd pulses.
- i_rst asserted at beat 100 of a burst → o_gnt, o_busy and o_data_valid are 0 after that edge. The next grant after release goes to ch0.
- With POOL_ARB_WATCHDOG_EN, granted ch1 holds valid low for 64 cycles after beat 10 → o_err=1, burst aborted, next request served is ch2. Without the macro, the grant holds indefinitely and o_err stays 0.
